// File: rtl/silencer_pkg.sv
// Shared constants and state type for the silencer slew limiter.
package silencer_pkg;

    localparam int SIL_WIDTH = 13;
    localparam int SIL_DEPTH = 249;
    localparam int SIL_IDX_W = $clog2(SIL_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/silencer_step_unit.sv
// Combinational one-step slew toward a target; i_wrap selects circular (phase)
// arithmetic modulo i_cycle, otherwise linear (duty) arithmetic.
module silencer_step_unit
    import silencer_pkg::*;
#(
    parameter int WIDTH = SIL_WIDTH
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_tgt,
    input  logic [WIDTH-1:0] i_cycle,
    input  logic [WIDTH-1:0] i_step,
    input  logic             i_wrap,
    output logic [WIDTH-1:0] o_next
);

    logic        [WIDTH:0] w_cur;
    logic        [WIDTH:0] w_tgt;
    logic        [WIDTH:0] w_cyc;
    logic        [WIDTH:0] w_stp;
    logic signed [WIDTH:0] w_diff;
    logic signed [WIDTH:0] w_diff_wr;
    logic        [WIDTH:0] w_mag;
    logic        [WIDTH:0] w_dist;
    logic        [WIDTH:0] w_rev;
    logic        [WIDTH:0] w_half;
    logic        [WIDTH:0] w_up;
    logic        [WIDTH:0] w_up_wr;
    logic        [WIDTH:0] w_dn;
    logic        [WIDTH:0] w_dn_wr;

    assign w_cur     = {1'b0, i_cur};
    assign w_tgt     = {1'b0, i_tgt};
    assign w_cyc     = {1'b0, i_cycle};
    assign w_stp     = {1'b0, i_step};
    assign w_diff    = $signed(w_tgt) - $signed(w_cur);
    assign w_diff_wr = w_diff + $signed(w_cyc);

    assign w_mag  = w_diff[WIDTH] ? (w_cur - w_tgt) : $unsigned(w_diff);
    // Forward circular distance, folded into 0..cycle-1
    assign w_dist = w_diff[WIDTH] ? $unsigned(w_diff_wr) : $unsigned(w_diff);
    assign w_rev  = w_cyc - w_dist;
    assign w_half = w_cyc >> 1;

    assign w_up    = w_cur + w_stp;
    assign w_up_wr = (w_up >= w_cyc) ? (w_up - w_cyc) : w_up;
    assign w_dn    = w_cur - w_stp;
    assign w_dn_wr = (w_cur < w_stp) ? (w_cur + w_cyc - w_stp) : w_dn;

    always_comb begin
        o_next = i_cur;
        if (!i_wrap) begin
            if (w_mag <= w_stp)
                o_next = i_tgt;
            else if (w_diff[WIDTH])
                o_next = w_dn[WIDTH-1:0];
            else
                o_next = w_up[WIDTH-1:0];
        end else begin
            if ((w_dist == '0) || (w_dist <= w_stp) || (w_rev <= w_stp))
                o_next = i_tgt;
            else if (w_dist <= w_half)
                o_next = w_up_wr[WIDTH-1:0];
            else
                o_next = w_dn_wr[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/silencer_core.sv
// Per-transducer duty/phase slew limiter, one element per cycle per pass.
// Define SILENCER_BYPASS_EN to copy targets straight through (no slew limiting).
module silencer_core
    import silencer_pkg::*;
#(
    parameter int WIDTH = SIL_WIDTH,
    parameter int DEPTH = SIL_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_din_valid,
    input  logic [WIDTH-1:0]       i_step,
    input  logic [WIDTH*DEPTH-1:0] i_cycle,
    input  logic [WIDTH*DEPTH-1:0] i_duty,
    input  logic [WIDTH*DEPTH-1:0] i_phase,
    output logic [WIDTH*DEPTH-1:0] o_duty_s,
    output logic [WIDTH*DEPTH-1:0] o_phase_s,
    output logic                   o_dout_valid
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_start;
    logic             w_write;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_step;
    logic             r_dout_valid;

    logic [WIDTH-1:0] r_duty_s    [DEPTH];
    logic [WIDTH-1:0] r_phase_s   [DEPTH];
    logic [WIDTH-1:0] w_cyc_arr   [DEPTH];
    logic [WIDTH-1:0] w_duty_arr  [DEPTH];
    logic [WIDTH-1:0] w_phase_arr [DEPTH];

    logic [WIDTH-1:0] w_duty_nxt;
    logic [WIDTH-1:0] w_phase_nxt;

    for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
        assign w_cyc_arr[g]                = i_cycle[g*WIDTH +: WIDTH];
        assign w_duty_arr[g]               = i_duty[g*WIDTH +: WIDTH];
        assign w_phase_arr[g]              = i_phase[g*WIDTH +: WIDTH];
        assign o_duty_s[g*WIDTH +: WIDTH]  = r_duty_s[g];
        assign o_phase_s[g*WIDTH +: WIDTH] = r_phase_s[g];
    end

`ifdef SILENCER_BYPASS_EN
    assign w_duty_nxt  = w_duty_arr[r_idx];
    assign w_phase_nxt = w_phase_arr[r_idx];
`else
    silencer_step_unit #(.WIDTH(WIDTH)) u_duty_step (
        .i_cur   (r_duty_s[r_idx]),
        .i_tgt   (w_duty_arr[r_idx]),
        .i_cycle (w_cyc_arr[r_idx]),
        .i_step  (r_step),
        .i_wrap  (1'b0),
        .o_next  (w_duty_nxt)
    );

    silencer_step_unit #(.WIDTH(WIDTH)) u_phase_step (
        .i_cur   (r_phase_s[r_idx]),
        .i_tgt   (w_phase_arr[r_idx]),
        .i_cycle (w_cyc_arr[r_idx]),
        .i_step  (r_step),
        .i_wrap  (1'b1),
        .o_next  (w_phase_nxt)
    );
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_din_valid) begin
                    w_state_nxt = ST_RUN;
                    w_start     = 1'b1;
                end
            end
            ST_RUN: begin
                w_write = 1'b1;
                if (r_idx == LAST_IDX)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_step       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            // High exactly while in DONE, so back-to-back passes leave a low gap
            r_dout_valid <= (w_state_nxt == ST_DONE);
            if (w_start) begin
                r_step <= i_step;
                r_idx  <= '0;
            end else if (w_write) begin
                r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_duty_s[i]  <= '0;
                r_phase_s[i] <= '0;
            end
        end else if (w_write) begin
            r_duty_s[r_idx]  <= w_duty_nxt;
            r_phase_s[r_idx] <= w_phase_nxt;
        end
    end

    assign o_dout_valid = r_dout_valid;

endmodule

// File: tb/tb_silencer_core.sv
// Randomized bench for silencer_core against a circular-distance reference model.
module tb_silencer_core;
    import silencer_pkg::*;

    localparam int W = SIL_WIDTH;
    localparam int D = SIL_DEPTH;

    logic           clk = 1'b0;
    logic           rst;
    logic           din_valid;
    logic [W-1:0]   step;
    logic [W*D-1:0] cycle_v, duty_v, phase_v, duty_s, phase_s;
    logic           dout_valid;

    silencer_core #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_din_valid  (din_valid),
        .i_step       (step),
        .i_cycle      (cycle_v),
        .i_duty       (duty_v),
        .i_phase      (phase_v),
        .o_duty_s     (duty_s),
        .o_phase_s    (phase_s),
        .o_dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc[D], tduty[D], tphase[D], mduty[D], mphase[D];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int m_duty(int cur, int tgt, int s);
`ifdef SILENCER_BYPASS_EN
        return tgt;
`else
        int dl = tgt - cur;
        if (dl <= s && -dl <= s) return tgt;
        return (dl > 0) ? cur + s : cur - s;
`endif
    endfunction

    function automatic int m_phase(int cur, int tgt, int c, int s);
`ifdef SILENCER_BYPASS_EN
        return tgt;
`else
        int up = (((tgt - cur) % c) + c) % c;
        int dn = (c - up) % c;
        if (up <= s || dn <= s) return tgt;
        if (up <= c / 2) return (cur + s) % c;
        return (((cur - s) % c) + c) % c;
`endif
    endfunction

    function automatic int get_duty(int i);
        return int'(duty_s[i*W +: W]);
    endfunction

    function automatic int get_phase(int i);
        return int'(phase_s[i*W +: W]);
    endfunction

    task automatic drive_targets();
        for (int i = 0; i < D; i++) begin
            cycle_v[i*W +: W] = W'(cyc[i]);
            duty_v[i*W +: W]  = W'(tduty[i]);
            phase_v[i*W +: W] = W'(tphase[i]);
        end
    endtask

    task automatic new_targets();
        for (int i = 0; i < D; i++) begin
            tduty[i]  = $urandom_range(cyc[i], 0);
            tphase[i] = $urandom_range(cyc[i] - 1, 0);
        end
    endtask

    task automatic model_pass(input int s);
        for (int i = 0; i < D; i++) begin
            mduty[i]  = m_duty(mduty[i], tduty[i], s);
            mphase[i] = m_phase(mphase[i], tphase[i], cyc[i], s);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < D; i++) begin
            chk($sformatf("%s_duty%0d", tag, i), get_duty(i), mduty[i]);
            chk($sformatf("%s_phase%0d", tag, i), get_phase(i), mphase[i]);
        end
    endtask

    // Starts one pass from IDLE; scrambles STEP mid-pass to prove it was latched.
    task automatic run_pass(input int s);
        bit seen = 0;
        step      = W'(s);
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        step      = W'($urandom_range(8191, 0));
        for (int k = 0; k < D + 20; k++) begin
            @(negedge clk);
            if (dout_valid) begin
                seen = 1;
                break;
            end
        end
        chk("pass_done", int'(seen), 1);
        @(negedge clk);
        model_pass(s);
    endtask

    task automatic converge_round(input string tag, input bit directed);
        for (int p = 1; p <= 80; p++) begin
            run_pass(100);
            check_all(tag);
            if (directed) begin
                if (p == 1)  chk("ramp_p1", get_duty(0), 100);
                if (p == 79) chk("ramp_p79", get_duty(0), 7900);
                if (p == 80) chk("ramp_p80", get_duty(0), 7999);
                if (p == 1)  chk("wrap_p1", get_phase(1), 3996);
                if (p >= 2)  chk("wrap_hold", get_phase(1), 3900);
                if (p == 1)  chk("snap_p1", get_phase(3), 4000);
                if (p <= 20) chk("tie_path", get_phase(2), 100 * p);
                if (p > 20)  chk("tie_hold", get_phase(2), 2000);
            end
            if (p == 40)
                for (int i = 0; i < D; i++) chk("phase_conv40", get_phase(i), tphase[i]);
            if (p == 80)
                for (int i = 0; i < D; i++) chk("duty_conv80", get_duty(i), tduty[i]);
        end
    endtask

    initial begin
        int n, last, cnt;
        rst = 1'b1; din_valid = 1'b0; step = '0;
        for (int i = 0; i < D; i++) begin
            cyc[i] = $urandom_range(8000, 2000);
            mduty[i] = 0; mphase[i] = 0;
        end
        new_targets();
        cyc[0] = 8000; tduty[0] = 7999; tphase[0] = 0;
        cyc[1] = 4096; tduty[1] = 0;    tphase[1] = 3900;
        cyc[2] = 4000; tduty[2] = 0;    tphase[2] = 2000;
        cyc[3] = 4096; tduty[3] = 0;    tphase[3] = 4000;
        drive_targets();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dout", int'(dout_valid), 0);
        chk("rst_duty0", get_duty(0), 0);
        chk("rst_phase1", get_phase(1), 0);

        converge_round("r1", 1'b1);
        new_targets();
        drive_targets();
        converge_round("r2", 1'b0);

        // Reset in the middle of a pass
        step = W'(100); din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dout", int'(dout_valid), 0);
        for (int i = 0; i < D; i++) begin
            chk("midrst_duty", get_duty(i), 0);
            chk("midrst_phase", get_phase(i), 0);
            mduty[i] = 0; mphase[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < D + 50; k++) begin
            @(negedge clk);
            if (dout_valid) cnt++;
        end
        chk("no_dout_after_rst", cnt, 0);
        run_pass(100);
        check_all("post_rst");

        // Continuous mode with STEP=0, then drop DIN_VALID mid-pass
        step = '0; din_valid = 1'b1;
        n = 0; last = -1;
        for (int k = 0; k < 4 * (D + 2) && n < 3; k++) begin
            @(negedge clk);
            if (dout_valid) begin
                if (last >= 0) chk("pulse_gap", k - last, D + 2);
                last = k;
                n++;
            end
        end
        chk("pulse_count", n, 3);
        cnt = 0;
        for (int k = 0; k < 3 * (D + 2); k++) begin
            @(negedge clk);
            if (k == 100) din_valid = 1'b0;
            if (dout_valid) cnt++;
        end
        chk("drop_pulses", cnt, 1);
        check_all("step0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
